// File: rtl/ds1302_pkg.sv
// Shared types and constants for the DS1302 device-side responder:
// FSM states, register indices, command byte layout and reset values.
package ds1302_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WDATA,
    ST_RDATA,
    ST_DONE
  } state_t;

  localparam logic [2:0] IDX_SEC   = 3'd0;
  localparam logic [2:0] IDX_MIN   = 3'd1;
  localparam logic [2:0] IDX_HOUR  = 3'd2;
  localparam logic [2:0] IDX_DATE  = 3'd3;
  localparam logic [2:0] IDX_MONTH = 3'd4;
  localparam logic [2:0] IDX_DAY   = 3'd5;
  localparam logic [2:0] IDX_YEAR  = 3'd6;
  localparam logic [2:0] IDX_WP    = 3'd7;
  localparam logic [4:0] IDX_BURST = 5'd31;

  localparam int CMD_RD_BIT   = 0;
  localparam int CMD_IDX_LSB  = 1;
  localparam int CMD_IDX_MSB  = 5;
  localparam int CMD_RAM_BIT  = 6;
  localparam int CMD_MARK_BIT = 7;

  localparam logic [7:0] RST_SEC   = 8'h80;
  localparam logic [7:0] RST_MIN   = 8'h00;
  localparam logic [7:0] RST_HOUR  = 8'h00;
  localparam logic [7:0] RST_DATE  = 8'h01;
  localparam logic [7:0] RST_MONTH = 8'h01;
  localparam logic [7:0] RST_DAY   = 8'h01;
  localparam logic [7:0] RST_YEAR  = 8'h00;
  localparam logic       RST_WP    = 1'b1;

  // Index 7 returns the WP register as it reads back: {wp, 7'b0}.
  function automatic logic [7:0] reset_value(input logic [2:0] idx);
    case (idx)
      IDX_SEC:   return RST_SEC;
      IDX_MIN:   return RST_MIN;
      IDX_HOUR:  return RST_HOUR;
      IDX_DATE:  return RST_DATE;
      IDX_MONTH: return RST_MONTH;
      IDX_DAY:   return RST_DAY;
      IDX_YEAR:  return RST_YEAR;
      default:   return {RST_WP, 7'b0};
    endcase
  endfunction

endpackage

// File: rtl/ds1302_responder_if.sv
// CE/SCLK/IO bus between the DS1302 command sequencer (master) and the responder (slave).
interface ds1302_responder_if;
  logic ce;
  logic sclk;
  logic io_in;
  logic io_out;
  logic io_oe;

  modport master (output ce, output sclk, output io_in, input io_out, input io_oe);
  modport slave  (input ce, input sclk, input io_in, output io_out, output io_oe);
endinterface

// File: rtl/ds1302_pin_sync.sv
// Multi-stage synchronizers on the bus pins with rise/fall detection for ce and sclk.
module ds1302_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic ce,
  input  logic sclk,
  input  logic io_in,
  output logic ce_lvl,
  output logic ce_rise,
  output logic ce_fall,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic io_lvl
);

  logic [SYNC_STAGES-1:0] ce_sync;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] io_sync;
  logic                   ce_prev;
  logic                   sclk_prev;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      ce_sync   <= '0;
      sclk_sync <= '0;
      io_sync   <= '0;
      ce_prev   <= 1'b0;
      sclk_prev <= 1'b0;
    end else begin
      ce_sync   <= {ce_sync[SYNC_STAGES-2:0], ce};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      io_sync   <= {io_sync[SYNC_STAGES-2:0], io_in};
      ce_prev   <= ce_sync[SYNC_STAGES-1];
      sclk_prev <= sclk_sync[SYNC_STAGES-1];
    end
  end

  assign ce_lvl    = ce_sync[SYNC_STAGES-1];
  assign ce_rise   = ce_lvl & ~ce_prev;
  assign ce_fall   = ~ce_lvl & ce_prev;
  assign sclk_rise = sclk_sync[SYNC_STAGES-1] & ~sclk_prev;
  assign sclk_fall = ~sclk_sync[SYNC_STAGES-1] & sclk_prev;
  assign io_lvl    = io_sync[SYNC_STAGES-1];

endmodule

// File: rtl/ds1302_responder.sv
// Device-side DS1302 model: decodes commands, commits register writes, serves reads.
// Clock burst (index 31) is compiled in only when DS1302_BURST_EN is defined.
module ds1302_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  ds1302_responder_if.slave   bus,
  output logic [55:0]         rtc_time,
  output logic                wp,
  output logic                wr_pulse,
  output logic [2:0]          wr_index
);
  import ds1302_pkg::*;

`ifdef DS1302_BURST_EN
  localparam bit BURST_EN = 1'b1;
`else
  localparam bit BURST_EN = 1'b0;
`endif

  logic ce_lvl, ce_rise, ce_fall, sclk_rise, sclk_fall, io_lvl;

  ds1302_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_pin_sync (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .ce        (bus.ce),
    .sclk      (bus.sclk),
    .io_in     (bus.io_in),
    .ce_lvl    (ce_lvl),
    .ce_rise   (ce_rise),
    .ce_fall   (ce_fall),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .io_lvl    (io_lvl)
  );

  state_t      state;
  logic [6:0]  bit_cnt;
  logic [7:0]  shift_reg;
  logic [7:0]  shift_next;
  logic [2:0]  cmd_idx;
  logic        cmd_burst;
  logic        burst_ok;
  logic        burst_busy;
  logic [2:0]  burst_cnt;
  logic [7:0]  shadow [8];
  logic [7:0]  time_reg [7];
  logic        wp_reg;
  logic [4:0]  dec_idx;
  logic        dec_ok;
  logic [2:0]  rd_sel;
  logic [7:0]  rd_byte;
  logic [6:0]  rd_len;

  // Serial data arrives LSB first, so each new bit enters at the top.
  assign shift_next = {io_lvl, shift_reg[7:1]};
  assign dec_idx    = shift_next[CMD_IDX_MSB:CMD_IDX_LSB];
  assign dec_ok     = shift_next[CMD_MARK_BIT] && !shift_next[CMD_RAM_BIT] &&
                      ((dec_idx <= 5'd7) || (BURST_EN && dec_idx == IDX_BURST));

  assign rd_sel  = cmd_burst ? bit_cnt[5:3] : cmd_idx;
  assign rd_byte = (rd_sel == IDX_WP) ? {wp_reg, 7'b0} : time_reg[rd_sel];
  assign rd_len  = cmd_burst ? 7'd64 : 7'd8;

  assign rtc_time = {time_reg[6], time_reg[5], time_reg[4], time_reg[3],
                     time_reg[2], time_reg[1], time_reg[0]};
  assign wp       = wp_reg;

  // A completed burst write drains the shadow buffer one index per cycle,
  // independent of the bus FSM, so a ce drop after the 64th bit cannot cut it short.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      cmd_idx    <= '0;
      cmd_burst  <= 1'b0;
      burst_ok   <= 1'b0;
      burst_busy <= 1'b0;
      burst_cnt  <= '0;
      for (int i = 0; i < 8; i++) shadow[i] <= '0;
      for (int i = 0; i < 7; i++) time_reg[i] <= reset_value(3'(i));
      wp_reg     <= RST_WP;
      bus.io_out <= 1'b0;
      bus.io_oe  <= 1'b0;
      wr_pulse   <= 1'b0;
      wr_index   <= '0;
    end else begin
      wr_pulse <= 1'b0;

      if (burst_busy) begin
        if (burst_cnt == IDX_WP) wp_reg <= shadow[7][7];
        else                     time_reg[burst_cnt] <= shadow[burst_cnt];
        wr_pulse  <= 1'b1;
        wr_index  <= burst_cnt;
        burst_cnt <= burst_cnt + 3'd1;
        if (burst_cnt == 3'd7) burst_busy <= 1'b0;
      end

      // ce low outranks any sclk edge detected in the same cycle.
      if (ce_fall || !ce_lvl) begin
        state     <= ST_IDLE;
        bit_cnt   <= '0;
        bus.io_oe <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (ce_rise) begin
              state   <= ST_CMD;
              bit_cnt <= '0;
            end
          end
          ST_CMD: begin
            if (sclk_rise) begin
              shift_reg <= shift_next;
              bit_cnt   <= bit_cnt + 7'd1;
              if (bit_cnt == 7'd7) begin
                bit_cnt   <= '0;
                cmd_idx   <= dec_idx[2:0];
                cmd_burst <= (dec_idx == IDX_BURST);
                burst_ok  <= !wp_reg;
                if (!dec_ok)                      state <= ST_DONE;
                else if (shift_next[CMD_RD_BIT])  state <= ST_RDATA;
                else                              state <= ST_WDATA;
              end
            end
          end
          ST_WDATA: begin
            if (sclk_rise) begin
              shift_reg <= shift_next;
              bit_cnt   <= bit_cnt + 7'd1;
              if (bit_cnt[2:0] == 3'd7) begin
                if (cmd_burst) begin
                  shadow[bit_cnt[5:3]] <= shift_next;
                  if (bit_cnt == 7'd63) begin
                    state <= ST_DONE;
                    if (burst_ok) begin
                      time_reg[0] <= shadow[0];
                      wr_pulse    <= 1'b1;
                      wr_index    <= IDX_SEC;
                      burst_busy  <= 1'b1;
                      burst_cnt   <= 3'd1;
                    end
                  end
                end else begin
                  state <= ST_DONE;
                  if (cmd_idx == IDX_WP) begin
                    wp_reg   <= shift_next[7];
                    wr_pulse <= 1'b1;
                    wr_index <= IDX_WP;
                  end else if (!wp_reg) begin
                    time_reg[cmd_idx] <= shift_next;
                    wr_pulse          <= 1'b1;
                    wr_index          <= cmd_idx;
                  end
                end
              end
            end
          end
          ST_RDATA: begin
            if (sclk_fall) begin
              if (bit_cnt == rd_len) begin
                bus.io_oe <= 1'b0;
                state     <= ST_DONE;
              end else begin
                bus.io_out <= rd_byte[bit_cnt[2:0]];
                bus.io_oe  <= 1'b1;
                bit_cnt    <= bit_cnt + 7'd1;
              end
            end
          end
          default: begin
            state <= ST_DONE;
          end
        endcase
      end
    end
  end

endmodule
